pwm_led_driver: RTL



---
 rtl/pwm_led_driver_pkg.sv | 9 +
 rtl/pwm_led_driver_timebase.sv | 43 ++++
 rtl/pwm_led_driver.sv | 86 ++++++++
 3 files changed

// File: rtl/pwm_led_driver_pkg.sv
// Shared helpers for the PWM LED driver slice.
package pwm_led_driver_pkg;

  // Prescaler counter width; a prescale of 1 still needs a 1-bit counter.
  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/pwm_led_driver_timebase.sv
// PWM timebase: prescaler plus free-running phase counter, both held at zero while disabled.
module pwm_led_driver_timebase
  import pwm_led_driver_pkg::*;
#(
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [DUTY_W-1:0] phase_q,
  output logic              tick,
  output logic              start_qual
);

  localparam int PRE_W = pre_width(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q;

  assign tick       = enable && (pre_q == PRE_LAST);
  assign start_qual = enable && (phase_q == '0) && (pre_q == '0);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      pre_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Phase wraps from all-ones to zero by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      phase_q <= '0;
    end else if (tick) begin
      phase_q <= phase_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_led_driver.sv
// Multi-channel PWM LED driver with double-buffered duty values applied at period boundaries.
module pwm_led_driver
  import pwm_led_driver_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS*DUTY_W-1:0] duty_in,
  input  logic                       duty_load,
  input  logic                       enable,
  output logic [CHANNELS-1:0]        pwm_out,
  output logic                       period_start,
  output logic                       pending
);

  logic [DUTY_W-1:0] phase_q;
  logic              tick;
  logic              start_qual;
  logic              wrap;
  logic              apply;

  pwm_led_driver_timebase #(
    .DUTY_W  (DUTY_W),
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .phase_q   (phase_q),
    .tick      (tick),
    .start_qual(start_qual)
  );

  // New duties may only land at a period boundary, or at any time while idle.
  assign wrap  = tick && (&phase_q);
  assign apply = !enable || wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (duty_load) begin
      pending <= !apply;
    end else if (apply) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= start_qual;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [DUTY_W-1:0] duty_word;
    logic [DUTY_W-1:0] shadow_q;
    logic [DUTY_W-1:0] active_q;

    assign duty_word = duty_in[i*DUTY_W +: DUTY_W];

    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q   <= '0;
        active_q   <= '0;
        pwm_out[i] <= 1'b0;
      end else begin
        if (duty_load) begin
          shadow_q <= duty_word;
        end
        // A load coinciding with the boundary bypasses the shadow.
        if (duty_load && apply) begin
          active_q <= duty_word;
        end else if (apply && pending) begin
          active_q <= shadow_q;
        end
        pwm_out[i] <= enable && (phase_q < active_q);
      end
    end
  end

endmodule
